c3lib_tie_ovrd_ctrl: RTL and testbench
======================================

# c3lib_tie_ovrd_ctrl

Sequencer for a bank of configuration strap outputs that power up at metal tie-low values and can later be overridden by software. Holds a shadow register, applies shadow contents atomically on commit, and reverts to the tie-low state on request. Each change is followed by a programmable settle window before the change is acknowledged. Sits between the CSR/sideband interface and analog/PHY strap inputs that would otherwise connect directly to tie-low cells.

## Interface
Parameters:
- WIDTH, 16, number of strap bits controlled
- SETTLE_CYC, 4, settle window in clk cycles after any cfg_out change; legal range 1..255

Ports:
- Clock is `clk`, and reset is `rst`, which is asynchronous and active-high.
- clk  input  1  block clock
- rst  input  1  asynchronous active-high reset
- wr_en  input  1  single-cycle strobe that loads wr_data into the shadow register
- wr_data  input  WIDTH  shadow write data
- commit_req  input  1  single-cycle pulse: apply shadow to cfg_out
- revert_req  input  1  single-cycle pulse: return cfg_out to tie-low
- cfg_out  output  WIDTH  strap values driven to the datapath
- cfg_ovrd  output  1  1 when the settled state is override (OVRD)
- busy  output  1  1 while in SETTLE
- done  output  1  one-cycle pulse at the end of each settle window
- shadow_q  output  WIDTH  current shadow contents (readback)

## Operation
- States: TIED, SETTLE, OVRD. A registered `target` bit records the destination state (TIED or OVRD).
- Reset values: state=TIED, cfg_out='0, shadow='0, cfg_ovrd=0, busy=0, done=0, counter=0.
- TIED:
  - commit_req sets cfg_out<=shadow, target=OVRD, and moves to SETTLE.
  - revert_req is ignored.
- OVRD:
  - commit_req sets cfg_out<=shadow, target=OVRD, and moves to SETTLE (re-apply).
  - revert_req sets cfg_out<='0, target=TIED, and moves to SETTLE.
  - If both requests arrive in the same cycle, revert wins.
- SETTLE:
  - The counter loads SETTLE_CYC-1 on entry and decrements each cycle.
  - When the counter is 0: done=1 for one cycle, then the next state is `target`.
  - commit_req and revert_req are ignored while in SETTLE; they are not queued.
- Shadow writes:
  - wr_en is accepted in every state. It changes only the shadow, never cfg_out directly.
  - If wr_en and commit_req occur in the same cycle, the commit applies wr_data (write-through).
- cfg_ovrd is 1 only in OVRD. It is 0 in SETTLE, including a re-apply from OVRD.
- Counter width is $clog2(SETTLE_CYC+1). It never wraps, because it is reloaded on each SETTLE entry.

## Timing
- A request sampled at edge N updates cfg_out and sets busy=1 after edge N.
- busy stays high for SETTLE_CYC cycles.
- done is high in the last SETTLE cycle. The state equals `target` after edge N+SETTLE_CYC.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Reset asserted mid-SETTLE: immediate return to the reset values above. cfg_out goes to '0 asynchronously and no done pulse is issued.
- Reset release: the block accepts requests on the first clk edge after rst deasserts. Reset-release synchronization is the integrator's responsibility.

## Configuration
- Macro: C3LIB_TIE_OVRD_PARITY_EN.
- When defined:
  - Adds input wr_par (even parity over wr_data), stored alongside the shadow.
  - Adds output cfg_err, reset 0.
  - A commit whose stored parity mismatches is rejected: cfg_out is unchanged, the state is unchanged, and cfg_err=1 for one cycle with no done pulse.
  - revert_req is unaffected.
- When undefined: no parity storage, no wr_par or cfg_err ports, and every commit is accepted.

## Structure
- Package c3lib_tie_ovrd_pkg holds:
  - the state enum tie_ovrd_state_e {TIED, SETTLE, OVRD}, encoded 2'b00/2'b01/2'b10
  - localparam TIE_VAL='0 (the tie-low value)
- Sub-module c3lib_tie_ovrd_settle_cnt contains the loadable down-counter. Its inputs are load and load_val; its outputs are zero and cnt.
- Top level contains the FSM, shadow register, cfg_out register and parity logic.

## Test plan
- Reset, then idle 10 cycles -> cfg_out=16'h0000, cfg_ovrd=0, busy=0, done=0.
- wr_data=16'hA5C3 with wr_en, then commit_req 2 cycles later (SETTLE_CYC=4) -> cfg_out=A5C3 one cycle after the request, busy for 4 cycles, done on the 4th, then cfg_ovrd=1.
- In OVRD, send commit_req and revert_req in the same cycle -> cfg_out=0000, a settle window follows, and the block ends in TIED with cfg_ovrd=0.
- commit_req during SETTLE, plus revert_req while in TIED -> both ignored, cfg_out unchanged, and only one done pulse in total.
- wr_en(16'h00FF) in the same cycle as commit_req -> cfg_out=00FF; also assert rst mid-SETTLE -> cfg_out=0000 immediately and no done pulse.
- With C3LIB_TIE_OVRD_PARITY_EN: write 16'h0001 with wr_par=0, then commit_req -> cfg_err pulses, cfg_out stays 0000, and no done pulse.

Source files
------------

// File: rtl/c3lib_tie_ovrd_pkg.sv
// Shared types and constants for the tie-low override sequencer.
package c3lib_tie_ovrd_pkg;

  typedef enum logic [1:0] {
    TIED   = 2'b00,
    SETTLE = 2'b01,
    OVRD   = 2'b10
  } tie_ovrd_state_e;

  // Value a strap bit takes when driven by its metal tie-low cell.
  localparam logic TIE_VAL = '0;

  function automatic int unsigned settle_cnt_width(input int unsigned settle_cyc);
    return $clog2(settle_cyc + 1);
  endfunction

endpackage

// File: rtl/c3lib_tie_ovrd_settle_cnt.sv
// Loadable saturating down-counter timing the post-change settle window.
module c3lib_tie_ovrd_settle_cnt #(
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/c3lib_tie_ovrd_ctrl.sv
// Strap override sequencer: shadow register, atomic commit/revert, settle window.
// Optional parity checking on committed data is enabled by C3LIB_TIE_OVRD_PARITY_EN.
module c3lib_tie_ovrd_ctrl
  import c3lib_tie_ovrd_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned SETTLE_CYC = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
`ifdef C3LIB_TIE_OVRD_PARITY_EN
  input  logic             wr_par,
  output logic             cfg_err,
`endif
  input  logic             commit_req,
  input  logic             revert_req,
  output logic [WIDTH-1:0] cfg_out,
  output logic             cfg_ovrd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] shadow_q
);

  localparam int unsigned    CntW       = settle_cnt_width(SETTLE_CYC);
  localparam logic [CntW-1:0] SettleLoad = CntW'(SETTLE_CYC - 1);

  tie_ovrd_state_e  state_q, state_d;
  logic             target_ovrd_q, target_ovrd_d;
  logic [WIDTH-1:0] cfg_out_q, cfg_out_d;
  logic [WIDTH-1:0] shadow_d;
  logic             commit_ok;
  logic             commit_rej;
  logic             cnt_load;
  logic             cnt_zero;
  logic [CntW-1:0]  cnt;

  // A same-cycle write lands in the shadow and is what a commit applies.
  assign shadow_d = wr_en ? wr_data : shadow_q;

`ifdef C3LIB_TIE_OVRD_PARITY_EN
  logic par_q, par_d;
  logic cfg_err_q;

  assign par_d     = wr_en ? wr_par : par_q;
  assign commit_ok = ((^shadow_d) == par_d);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_q     <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      par_q     <= par_d;
      cfg_err_q <= commit_rej;
    end
  end

  assign cfg_err = cfg_err_q;
`else
  assign commit_ok = 1'b1;
`endif

  always_comb begin
    state_d       = state_q;
    target_ovrd_d = target_ovrd_q;
    cfg_out_d     = cfg_out_q;
    cnt_load      = 1'b0;
    commit_rej    = 1'b0;
    unique case (state_q)
      TIED: begin
        if (commit_req) begin
          if (commit_ok) begin
            cfg_out_d     = shadow_d;
            target_ovrd_d = 1'b1;
            state_d       = SETTLE;
            cnt_load      = 1'b1;
          end else begin
            commit_rej = 1'b1;
          end
        end
      end
      OVRD: begin
        // Revert takes priority over a simultaneous commit.
        if (revert_req) begin
          cfg_out_d     = {WIDTH{TIE_VAL}};
          target_ovrd_d = 1'b0;
          state_d       = SETTLE;
          cnt_load      = 1'b1;
        end else if (commit_req) begin
          if (commit_ok) begin
            cfg_out_d     = shadow_d;
            target_ovrd_d = 1'b1;
            state_d       = SETTLE;
            cnt_load      = 1'b1;
          end else begin
            commit_rej = 1'b1;
          end
        end
      end
      SETTLE: begin
        if (cnt_zero) begin
          state_d = target_ovrd_q ? OVRD : TIED;
        end
      end
      default: begin
        state_d   = TIED;
        cfg_out_d = {WIDTH{TIE_VAL}};
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= TIED;
      target_ovrd_q <= 1'b0;
      cfg_out_q     <= {WIDTH{TIE_VAL}};
      shadow_q      <= '0;
    end else begin
      state_q       <= state_d;
      target_ovrd_q <= target_ovrd_d;
      cfg_out_q     <= cfg_out_d;
      shadow_q      <= shadow_d;
    end
  end

  c3lib_tie_ovrd_settle_cnt #(
    .CNT_W (CntW)
  ) u_settle_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (SettleLoad),
    .zero     (cnt_zero),
    .cnt      (cnt)
  );

  // The counter is reloaded on every entry, so it can never exceed the load value.
  assert property (@(posedge clk) disable iff (rst) cnt <= SettleLoad);

  assign cfg_out  = cfg_out_q;
  assign busy     = (state_q == SETTLE);
  assign done     = (state_q == SETTLE) && cnt_zero;
  assign cfg_ovrd = (state_q == OVRD);

endmodule

// File: tb/tb_c3lib_tie_ovrd_ctrl.sv
// Directed bench for c3lib_tie_ovrd_ctrl with a cycle-level reference model.
module tb_c3lib_tie_ovrd_ctrl;

  localparam int unsigned W  = 16;
  localparam int unsigned SC = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         wr_en = 1'b0;
  logic [W-1:0] wr_data = '0;
  logic         wr_par = 1'b0;
  logic         commit_req = 1'b0;
  logic         revert_req = 1'b0;
  logic [W-1:0] cfg_out;
  logic         cfg_ovrd;
  logic         busy;
  logic         done;
  logic [W-1:0] shadow_q;
`ifdef C3LIB_TIE_OVRD_PARITY_EN
  logic         cfg_err;
`endif

  int cmp_cnt = 0;
  int err_cnt = 0;
  int done_seen = 0;

  always #5 clk = ~clk;

  c3lib_tie_ovrd_ctrl #(
    .WIDTH      (W),
    .SETTLE_CYC (SC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
`ifdef C3LIB_TIE_OVRD_PARITY_EN
    .wr_par     (wr_par),
    .cfg_err    (cfg_err),
`endif
    .commit_req (commit_req),
    .revert_req (revert_req),
    .cfg_out    (cfg_out),
    .cfg_ovrd   (cfg_ovrd),
    .busy       (busy),
    .done       (done),
    .shadow_q   (shadow_q)
  );

  // Reference model: settle window as "cycles left", settled mode as a flag.
  logic [W-1:0] m_cfg, m_shadow;
  logic         m_par, m_goal, m_ovrd, m_err;
  int           m_left;
  logic [W-1:0] m_new_shadow;
  logic         m_new_par, m_par_ok;

  assign m_new_shadow = wr_en ? wr_data : m_shadow;
  assign m_new_par    = wr_en ? wr_par : m_par;
`ifdef C3LIB_TIE_OVRD_PARITY_EN
  assign m_par_ok = ((^m_new_shadow) == m_new_par);
`else
  assign m_par_ok = 1'b1;
`endif

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cfg <= '0; m_shadow <= '0; m_par <= 1'b0; m_goal <= 1'b0;
      m_ovrd <= 1'b0; m_err <= 1'b0; m_left <= 0;
    end else begin
      m_shadow <= m_new_shadow;
      m_par    <= m_new_par;
      m_err    <= 1'b0;
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) m_ovrd <= m_goal;
      end else if (m_ovrd && revert_req) begin
        m_cfg <= '0; m_goal <= 1'b0; m_left <= SC; m_ovrd <= 1'b0;
      end else if (commit_req && m_par_ok) begin
        m_cfg <= m_new_shadow; m_goal <= 1'b1; m_left <= SC; m_ovrd <= 1'b0;
      end else if (commit_req) begin
        m_err <= 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("cyc_cfg_out", 32'(cfg_out), 32'(m_cfg));
      check("cyc_shadow", 32'(shadow_q), 32'(m_shadow));
      check("cyc_busy", 32'(busy), 32'(m_left != 0));
      check("cyc_done", 32'(done), 32'(m_left == 1));
      check("cyc_cfg_ovrd", 32'(cfg_ovrd), 32'(m_left == 0 && m_ovrd));
`ifdef C3LIB_TIE_OVRD_PARITY_EN
      check("cyc_cfg_err", 32'(cfg_err), 32'(m_err));
`endif
      if (done) done_seen <= done_seen + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int d0;

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    repeat (10) tick();
    check("rst_cfg_out", 32'(cfg_out), 32'h0);
    check("rst_cfg_ovrd", 32'(cfg_ovrd), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);

    // Write A5C3, commit two cycles later.
    wr_en = 1'b1; wr_data = 16'hA5C3; wr_par = ^16'hA5C3;
    tick();
    wr_en = 1'b0;
    tick(); tick();
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    check("commit_cfg_out", 32'(cfg_out), 32'hA5C3);
    check("commit_busy", 32'(busy), 32'h1);
    check("commit_done_early", 32'(done), 32'h0);
    tick(); tick(); tick();
    check("commit_done_last", 32'(done), 32'h1);
    check("commit_busy_last", 32'(busy), 32'h1);
    tick();
    check("commit_busy_end", 32'(busy), 32'h0);
    check("commit_ovrd", 32'(cfg_ovrd), 32'h1);
    check("model_cfg_pin", 32'(m_cfg), 32'hA5C3);

    // Simultaneous commit and revert from OVRD: revert wins.
    commit_req = 1'b1; revert_req = 1'b1;
    tick();
    commit_req = 1'b0; revert_req = 1'b0;
    check("revert_cfg_out", 32'(cfg_out), 32'h0);
    check("revert_busy", 32'(busy), 32'h1);
    repeat (SC) tick();
    check("revert_tied", 32'(cfg_ovrd), 32'h0);
    check("revert_idle", 32'(busy), 32'h0);

    // Revert while TIED, commit while SETTLE: both ignored.
    d0 = done_seen;
    revert_req = 1'b1;
    tick();
    revert_req = 1'b0;
    check("tied_revert_busy", 32'(busy), 32'h0);
    wr_en = 1'b1; wr_data = 16'h1234; wr_par = ^16'h1234; commit_req = 1'b1;
    tick();
    wr_en = 1'b0; commit_req = 1'b0;
    tick();
    wr_en = 1'b1; wr_data = 16'h5555; wr_par = ^16'h5555; commit_req = 1'b1;
    tick();
    wr_en = 1'b0; commit_req = 1'b0;
    check("settle_commit_cfg", 32'(cfg_out), 32'h1234);
    check("settle_wr_shadow", 32'(shadow_q), 32'h5555);
    repeat (SC + 1) tick();
    check("ignore_one_done", 32'(done_seen - d0), 32'h1);
    check("ignore_cfg_out", 32'(cfg_out), 32'h1234);
    check("ignore_ovrd", 32'(cfg_ovrd), 32'h1);

    // Write-through commit, then reset mid-SETTLE.
    wr_en = 1'b1; wr_data = 16'h00FF; wr_par = ^16'h00FF; commit_req = 1'b1;
    tick();
    wr_en = 1'b0; commit_req = 1'b0;
    check("wt_cfg_out", 32'(cfg_out), 32'h00FF);
    tick();
    d0 = done_seen;
    rst = 1'b1;
    #1;
    check("rst_mid_cfg_out", 32'(cfg_out), 32'h0);
    check("rst_mid_busy", 32'(busy), 32'h0);
    check("rst_mid_done", 32'(done), 32'h0);
    tick(); tick();
    rst = 1'b0;
    repeat (6) tick();
    check("rst_mid_no_done", 32'(done_seen - d0), 32'h0);
    check("rst_mid_shadow", 32'(shadow_q), 32'h0);
    check("rst_mid_ovrd", 32'(cfg_ovrd), 32'h0);

`ifdef C3LIB_TIE_OVRD_PARITY_EN
    // Bad parity on 0001 (odd data, par=0): commit rejected.
    d0 = done_seen;
    wr_en = 1'b1; wr_data = 16'h0001; wr_par = 1'b0;
    tick();
    wr_en = 1'b0;
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    check("par_err_pulse", 32'(cfg_err), 32'h1);
    check("par_cfg_out", 32'(cfg_out), 32'h0);
    check("par_busy", 32'(busy), 32'h0);
    tick();
    check("par_err_clear", 32'(cfg_err), 32'h0);
    repeat (SC) tick();
    check("par_no_done", 32'(done_seen - d0), 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
